mips_status_monitor: RTL and testbench
======================================

// Module: mips_status_monitor
// PURPOSE
//  Sits downstream of core: consumes o_status/o_status_valid and o_i_addr every cycle.
//  Counts retired instructions by class and bounds run length. Decides the end-of-run
//  verdict (END, OVERFLOW, TIMEOUT, MISALIGN, MAXCYC) as registered flags that the testbed
//  and FPGA wrapper poll instead of a fixed $finish delay.
// PARAMETERS
//  CNT_W      32      width of all counters
//  TIMEOUT    1024    consecutive RUN cycles without i_status_valid before TIMEOUT
//  MAX_CYCLE  120000  RUN cycles before MAXCYC verdict
// PORTS
//  i_clk          in   1      clock, rising edge
//  i_rst_n        in   1      asynchronous active-low reset
//  i_clr          in   1      sync clear: counters to 0, FSM to IDLE while high
//  i_status       in   2      0=R_TYPE ok, 1=I_TYPE ok, 2=OVERFLOW, 3=END
//  i_status_valid in   1      i_status qualifier, one cycle per retired instruction
//  i_i_addr       in   32     core instruction address (PC)
//  o_r_cnt        out  CNT_W  retired status-0 count
//  o_i_cnt        out  CNT_W  retired status-1 count
//  o_total_cnt    out  CNT_W  all valid statuses (0..3)
//  o_cycle_cnt    out  CNT_W  RUN cycles, incl. terminating cycle
//  o_last_pc      out  32     i_i_addr captured at last valid status
//  o_done         out  1      verdict reached, sticky
//  o_result       out  3      0 none,1 END,2 OVERFLOW,3 TIMEOUT,4 MISALIGN,5 MAXCYC
// BEHAVIOUR
//  Reset (async): all counters 0, o_last_pc 0, o_done 0, o_result 0, FSM IDLE, idle ctr 0.
//  FSM: IDLE -> RUN on first edge with i_clr=0. RUN -> HALT on a verdict. HALT holds
//   until i_clr=1 (-> IDLE). i_clr=1 in any state -> IDLE next edge, counters cleared.
//  In IDLE and HALT no counter moves. Inputs are ignored except i_clr.
//  RUN, per edge:
//   - cycle_cnt += 1.
//   - if i_status_valid: total_cnt += 1, last_pc <= i_i_addr, idle ctr <= 0;
//     status 0 -> r_cnt += 1; status 1 -> i_cnt += 1.
//   - else idle ctr += 1.
//   - all counters saturate at all-ones, no wrap.
//  Verdicts, evaluated on the same RUN edge. Priority high->low when several coincide:
//   MISALIGN: i_i_addr[1:0]!=0.
//   OVERFLOW: valid and status 2.
//   END:      valid and status 3.
//   MAXCYC:   cycle_cnt (pre-increment) == MAX_CYCLE-1.
//   TIMEOUT:  !valid and idle ctr (pre-increment) == TIMEOUT-1.
//  Latency: o_done/o_result update on the same edge that registers the verdict cycle's
//   counts, so the terminating instruction is counted. o_done/o_result are sticky in HALT.
//   Both return to 0 when IDLE is entered.
//  Valid status while in IDLE/HALT is dropped (not counted, no verdict).
//  Async reset mid-RUN aborts immediately to reset values. No partial verdict is kept.
//  All outputs are registered; no combinational input->output paths.
// TESTING
//  1) Reset, then 3 valid status 0, 2 valid status 1, then status 3, PC always 4-aligned ->
//     r=3, i=2, total=6, done=1, result=1, last_pc=PC of END cycle.
//  2) Valid status 2 on 5th instruction -> result=2, total=5. Later inputs leave counters frozen.
//  3) No valid for TIMEOUT cycles after IDLE exit -> done on cycle TIMEOUT, result=3,
//     cycle_cnt=TIMEOUT.
//  4) i_i_addr=0x0000_0006 with valid status 3 in the same cycle -> result=4 (priority).
//  5) MAX_CYCLE=50 override, valid every cycle, status 0 -> result=5, cycle_cnt=50, r=50.
//  6) In HALT assert i_clr 1 cycle -> all outputs 0. Drop async reset mid-RUN ->
//     immediate zero outputs. Then rerun test 1 -> identical counts.

Source files
------------

// File: rtl/mips_status_monitor_if.sv
// Status bus between the MIPS core side and the run monitor.
// The master drives the core's status stream; the slave owns the counters and verdict.
interface mips_status_monitor_if #(
    parameter int CNT_W = 32
);
    logic             i_clr;
    logic [1:0]       i_status;
    logic             i_status_valid;
    logic [31:0]      i_i_addr;
    logic [CNT_W-1:0] o_r_cnt;
    logic [CNT_W-1:0] o_i_cnt;
    logic [CNT_W-1:0] o_total_cnt;
    logic [CNT_W-1:0] o_cycle_cnt;
    logic [31:0]      o_last_pc;
    logic             o_done;
    logic [2:0]       o_result;

    modport master (
        output i_clr, i_status, i_status_valid, i_i_addr,
        input  o_r_cnt, o_i_cnt, o_total_cnt, o_cycle_cnt, o_last_pc, o_done, o_result
    );

    modport slave (
        input  i_clr, i_status, i_status_valid, i_i_addr,
        output o_r_cnt, o_i_cnt, o_total_cnt, o_cycle_cnt, o_last_pc, o_done, o_result
    );
endinterface

// File: rtl/mips_status_monitor.sv
// Counts retired MIPS instructions by class and registers a sticky end-of-run verdict
// (END, OVERFLOW, TIMEOUT, MISALIGN, MAXCYC) for the testbed / FPGA wrapper to poll.
module mips_status_monitor #(
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 1024,
    parameter int MAX_CYCLE = 120000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mips_status_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        RES_NONE     = 3'd0,
        RES_END      = 3'd1,
        RES_OVERFLOW = 3'd2,
        RES_TIMEOUT  = 3'd3,
        RES_MISALIGN = 3'd4,
        RES_MAXCYC   = 3'd5
    } result_e;

    localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_MAXCYC_LAST  = CNT_W'(MAX_CYCLE - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_r_cnt;
    logic [CNT_W-1:0] r_i_cnt;
    logic [CNT_W-1:0] r_total_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [31:0]      r_last_pc;
    logic             r_done;
    result_e          r_result;
    result_e          w_verdict;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Verdict priority: MISALIGN > OVERFLOW > END > MAXCYC > TIMEOUT, using pre-increment counts.
    always_comb begin
        w_verdict = RES_NONE;
        if (bus.i_i_addr[1:0] != 2'b00)
            w_verdict = RES_MISALIGN;
        else if (bus.i_status_valid && bus.i_status == 2'd2)
            w_verdict = RES_OVERFLOW;
        else if (bus.i_status_valid && bus.i_status == 2'd3)
            w_verdict = RES_END;
        else if (r_cycle_cnt == L_MAXCYC_LAST)
            w_verdict = RES_MAXCYC;
        else if (!bus.i_status_valid && r_idle_cnt == L_TIMEOUT_LAST)
            w_verdict = RES_TIMEOUT;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_r_cnt     <= '0;
            r_i_cnt     <= '0;
            r_total_cnt <= '0;
            r_cycle_cnt <= '0;
            r_idle_cnt  <= '0;
            r_last_pc   <= '0;
            r_done      <= 1'b0;
            r_result    <= RES_NONE;
        end else if (bus.i_clr) begin
            r_state     <= ST_IDLE;
            r_r_cnt     <= '0;
            r_i_cnt     <= '0;
            r_total_cnt <= '0;
            r_cycle_cnt <= '0;
            r_idle_cnt  <= '0;
            r_last_pc   <= '0;
            r_done      <= 1'b0;
            r_result    <= RES_NONE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_RUN;
                ST_RUN: begin
                    r_cycle_cnt <= sat_inc(r_cycle_cnt);
                    if (bus.i_status_valid) begin
                        r_total_cnt <= sat_inc(r_total_cnt);
                        r_last_pc   <= bus.i_i_addr;
                        r_idle_cnt  <= '0;
                        if (bus.i_status == 2'd0) r_r_cnt <= sat_inc(r_r_cnt);
                        if (bus.i_status == 2'd1) r_i_cnt <= sat_inc(r_i_cnt);
                    end else begin
                        r_idle_cnt <= sat_inc(r_idle_cnt);
                    end
                    // Counts above still update on the verdict edge so the last instruction is counted.
                    if (w_verdict != RES_NONE) begin
                        r_state  <= ST_HALT;
                        r_done   <= 1'b1;
                        r_result <= w_verdict;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_r_cnt     = r_r_cnt;
    assign bus.o_i_cnt     = r_i_cnt;
    assign bus.o_total_cnt = r_total_cnt;
    assign bus.o_cycle_cnt = r_cycle_cnt;
    assign bus.o_last_pc   = r_last_pc;
    assign bus.o_done      = r_done;
    assign bus.o_result    = r_result;
endmodule

// File: tb/tb_mips_status_monitor.sv
// Scoreboard bench for mips_status_monitor: stimulus queues expected verdict/snapshot records,
// a monitor compares them when o_done rises or when a snapshot is requested.
module tb_mips_status_monitor;
    logic clk;
    logic rst_n;
    logic stim_done;

    typedef struct {
        string       tag;
        logic        done;
        logic [2:0]  res;
        logic [31:0] r;
        logic [31:0] i;
        logic [31:0] tot;
        logic [31:0] cyc;
        logic [31:0] pc;
    } exp_t;

    exp_t doneq0[$];
    exp_t snapq0[$];
    exp_t doneq1[$];

    int unsigned n_checks;
    int unsigned n_fail;

    mips_status_monitor_if #(.CNT_W(32)) if0 ();
    mips_status_monitor_if #(.CNT_W(32)) if1 ();

    mips_status_monitor #(.CNT_W(32)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if0)
    );

    mips_status_monitor #(.CNT_W(32), .MAX_CYCLE(50)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(string tag, logic done, logic [2:0] res, logic [31:0] r,
                                logic [31:0] i, logic [31:0] tot, logic [31:0] cyc, logic [31:0] pc);
        exp_t e;
        e.tag = tag; e.done = done; e.res = res; e.r = r; e.i = i;
        e.tot = tot; e.cyc = cyc; e.pc = pc;
        return e;
    endfunction

    function automatic exp_t samp0();
        return mk("", if0.o_done, if0.o_result, if0.o_r_cnt, if0.o_i_cnt,
                  if0.o_total_cnt, if0.o_cycle_cnt, if0.o_last_pc);
    endfunction

    function automatic exp_t samp1();
        return mk("", if1.o_done, if1.o_result, if1.o_r_cnt, if1.o_i_cnt,
                  if1.o_total_cnt, if1.o_cycle_cnt, if1.o_last_pc);
    endfunction

    task automatic cmp(string tag, string f, logic [31:0] a, logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s.%s actual=0x%08h expected=0x%08h", tag, f, a, e);
        end
    endtask

    task automatic chk(exp_t a, exp_t e);
        cmp(e.tag, "done",   {31'd0, a.done}, {31'd0, e.done});
        cmp(e.tag, "result", {29'd0, a.res},  {29'd0, e.res});
        cmp(e.tag, "r_cnt",  a.r,   e.r);
        cmp(e.tag, "i_cnt",  a.i,   e.i);
        cmp(e.tag, "total",  a.tot, e.tot);
        cmp(e.tag, "cycle",  a.cyc, e.cyc);
        cmp(e.tag, "last_pc", a.pc, e.pc);
    endtask

    // Monitor: the only process that steps the check/failure counters.
    initial begin
        logic prev0, prev1;
        exp_t e;
        n_checks = 0;
        n_fail   = 0;
        prev0    = 1'b0;
        prev1    = 1'b0;
        while (!stim_done) begin
            @(negedge clk);
            while (snapq0.size() > 0) begin
                e = snapq0.pop_front();
                chk(samp0(), e);
            end
            if (if0.o_done && !prev0) begin
                if (doneq0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut0_unexpected_done actual=1 expected=0 result=%0d", if0.o_result);
                end else begin
                    e = doneq0.pop_front();
                    chk(samp0(), e);
                end
            end
            if (if1.o_done && !prev1) begin
                if (doneq1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut1_unexpected_done actual=1 expected=0 result=%0d", if1.o_result);
                end else begin
                    e = doneq1.pop_front();
                    chk(samp1(), e);
                end
            end
            prev0 = if0.o_done;
            prev1 = if1.o_done;
        end
        cmp("dut0_pending", "verdicts", doneq0.size(), 0);
        cmp("dut1_pending", "verdicts", doneq1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(logic v, logic [1:0] s, logic [31:0] a);
        if0.i_status_valid = v;
        if0.i_status       = s;
        if0.i_i_addr       = a;
    endtask

    task automatic drive1(logic v, logic [1:0] s, logic [31:0] a);
        if1.i_status_valid = v;
        if1.i_status       = s;
        if1.i_i_addr       = a;
    endtask

    task automatic wait_done0(int unsigned limit);
        for (int unsigned k = 0; k < limit && !if0.o_done; k++) step();
    endtask

    task automatic wait_done1(int unsigned limit);
        for (int unsigned k = 0; k < limit && !if1.o_done; k++) step();
    endtask

    // Starts in IDLE with i_clr low: 3 R-type, 2 I-type, then END at 0x414.
    task automatic run_t1(string tag);
        logic [1:0] s;
        drive0(1'b0, 2'd0, 32'h400);
        step();
        doneq0.push_back(mk(tag, 1'b1, 3'd1, 32'd3, 32'd2, 32'd6, 32'd6, 32'h414));
        for (int unsigned k = 0; k < 6; k++) begin
            s = (k < 3) ? 2'd0 : ((k < 5) ? 2'd1 : 2'd3);
            drive0(1'b1, s, 32'h400 + 32'(4 * k));
            step();
        end
        drive0(1'b0, 2'd0, 32'h418);
        wait_done0(4);
        step();
    endtask

    initial begin
        stim_done  = 1'b0;
        rst_n      = 1'b0;
        if0.i_clr  = 1'b0;
        if1.i_clr  = 1'b1;
        drive0(1'b0, 2'd0, 32'h0);
        drive1(1'b0, 2'd0, 32'h0);
        step();
        step();
        snapq0.push_back(mk("reset", 1'b0, 3'd0, 0, 0, 0, 0, 0));
        step();
        rst_n = 1'b1;

        run_t1("t1_end");

        // Overflow on 5th instruction, then further inputs must not move anything.
        if0.i_clr = 1'b1;
        step();
        snapq0.push_back(mk("clr_halt", 1'b0, 3'd0, 0, 0, 0, 0, 0));
        if0.i_clr = 1'b0;
        drive0(1'b0, 2'd0, 32'h500);
        step();
        doneq0.push_back(mk("t2_ovf", 1'b1, 3'd2, 32'd4, 32'd0, 32'd5, 32'd5, 32'h510));
        for (int unsigned k = 0; k < 5; k++) begin
            drive0(1'b1, (k < 4) ? 2'd0 : 2'd2, 32'h500 + 32'(4 * k));
            step();
        end
        for (int unsigned k = 0; k < 3; k++) begin
            drive0(1'b1, 2'(k), 32'h600 + 32'(4 * k));
            step();
        end
        snapq0.push_back(mk("t2_frozen", 1'b1, 3'd2, 32'd4, 32'd0, 32'd5, 32'd5, 32'h510));
        drive0(1'b0, 2'd0, 32'h600);
        step();

        // Timeout after 1024 idle RUN cycles.
        if0.i_clr = 1'b1;
        step();
        if0.i_clr = 1'b0;
        drive0(1'b0, 2'd0, 32'h100);
        step();
        doneq0.push_back(mk("t3_timeout", 1'b1, 3'd3, 0, 0, 0, 32'd1024, 0));
        wait_done0(1100);
        step();

        // Misaligned PC beats END in the same cycle.
        if0.i_clr = 1'b1;
        step();
        if0.i_clr = 1'b0;
        drive0(1'b0, 2'd0, 32'h40);
        step();
        doneq0.push_back(mk("t4_misalign", 1'b1, 3'd4, 32'd1, 32'd0, 32'd2, 32'd2, 32'h6));
        drive0(1'b1, 2'd0, 32'h40);
        step();
        drive0(1'b1, 2'd3, 32'h6);
        step();
        drive0(1'b0, 2'd0, 32'h44);
        wait_done0(4);
        step();

        // Clear from HALT, then async reset mid-run, then rerun the END sequence.
        if0.i_clr = 1'b1;
        step();
        snapq0.push_back(mk("t6_clr", 1'b0, 3'd0, 0, 0, 0, 0, 0));
        if0.i_clr = 1'b0;
        drive0(1'b0, 2'd0, 32'h80);
        step();
        drive0(1'b1, 2'd0, 32'h80);
        step();
        drive0(1'b1, 2'd1, 32'h84);
        step();
        drive0(1'b0, 2'd0, 32'h88);
        #2;
        rst_n = 1'b0;
        snapq0.push_back(mk("t6_async_rst", 1'b0, 3'd0, 0, 0, 0, 0, 0));
        step();
        step();
        rst_n = 1'b1;
        run_t1("t6_rerun");

        // MAX_CYCLE=50 instance: valid R-type every cycle.
        if1.i_clr = 1'b0;
        drive1(1'b1, 2'd0, 32'h1000);
        step();
        doneq1.push_back(mk("t5_maxcyc", 1'b1, 3'd5, 32'd50, 32'd0, 32'd50, 32'd50, 32'h10C8));
        for (int unsigned k = 1; k <= 50; k++) begin
            drive1(1'b1, 2'd0, 32'h1000 + 32'(4 * k));
            step();
        end
        drive1(1'b0, 2'd0, 32'h2000);
        wait_done1(4);
        step();
        step();
        stim_done = 1'b1;
    end
endmodule
